// File: rtl/mac_pkg.sv
// Shared constants and types for the multiply-accumulate unit.
package mac_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;
    localparam int CNT_W_DEF  = 4;
    localparam int PROD_W     = 2 * DATA_W_DEF;

    // Accumulator behaviour when a sum carries out of the result width.
    typedef enum logic {
        SAT_WRAP  = 1'b0,
        SAT_CLAMP = 1'b1
    } sat_mode_e;

    // Maps the integer SATURATE parameter onto the mode encoding.
    function automatic sat_mode_e sat_mode_from_param(input int sat);
        return (sat != 0) ? SAT_CLAMP : SAT_WRAP;
    endfunction

endpackage

// File: rtl/mac_accum_unit_if.sv
// Operand/result bus between a dot-product sequencer (master) and the MAC unit (slave).
interface mac_accum_unit_if
    import mac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);

    logic [DATA_W-1:0] data_in;
    logic              load_b_en;
    logic              load_c_en;
    logic              accum_en;
    logic              clear_en;
    logic [ACC_W-1:0]  result_out;
    logic              overflow;
    logic              busy;
    logic [CNT_W-1:0]  acc_count;

    modport master (
        output data_in, load_b_en, load_c_en, accum_en, clear_en,
        input  result_out, overflow, busy, acc_count
    );

    modport slave (
        input  data_in, load_b_en, load_c_en, accum_en, clear_en,
        output result_out, overflow, busy, acc_count
    );

endinterface

// File: rtl/mac_sat_adder.sv
// Combinational accumulator adder: one extra bit for carry-out, optional clamp to all-ones.
module mac_sat_adder
    import mac_pkg::*;
#(
    parameter int        ACC_W    = ACC_W_DEF,
    parameter int        ADD_W    = PROD_W,
    parameter sat_mode_e MODE     = SAT_WRAP
) (
    input  logic [ACC_W-1:0] acc_in,
    input  logic [ADD_W-1:0] addend,
    output logic [ACC_W-1:0] sum_out,
    output logic             carry_out
);

    localparam logic CLAMP_EN = (MODE == SAT_CLAMP);

    logic [ACC_W:0] sum_full;

    // Extend both operands to ACC_W+1 bits so the top bit is the carry-out.
    assign sum_full  = {1'b0, acc_in} + (ACC_W + 1)'(addend);
    assign carry_out = sum_full[ACC_W];

    // In clamp mode a carry forces every result bit high; otherwise the sum wraps.
    for (genvar gi = 0; gi < ACC_W; gi++) begin : g_clamp
        assign sum_out[gi] = sum_full[gi] | (CLAMP_EN & carry_out);
    end

endmodule

// File: rtl/mac_accum_unit.sv
// Two-stage multiply-accumulate responder: operand latches, product stage, accumulate stage.
module mac_accum_unit
    import mac_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int SATURATE = 0
) (
    input  logic           clk,
    input  logic           rst,
    mac_accum_unit_if.slave bus
);

    localparam int               OP_PROD_W = 2 * DATA_W;
    localparam sat_mode_e        MODE      = sat_mode_from_param(SATURATE);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [DATA_W-1:0]    b_reg;
    logic [DATA_W-1:0]    c_reg;
    logic [OP_PROD_W-1:0] prod_reg;
    logic                 v1_reg;
    logic                 v2_reg;
    logic [ACC_W-1:0]     acc_reg;
    logic                 ovf_reg;
    logic [CNT_W-1:0]     cnt_reg;

    logic [ACC_W-1:0]     sum_next;
    logic                 carry_next;

    // Operand latches; clear leaves them intact but takes priority over a same-cycle load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            b_reg <= '0;
            c_reg <= '0;
        end else if (!bus.clear_en) begin
            if (bus.load_b_en) b_reg <= bus.data_in;
            if (bus.load_c_en) c_reg <= bus.data_in;
        end
    end

    // Stage 1: multiply the operands held before this edge; v2 marks the retiring cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prod_reg <= '0;
            v1_reg   <= 1'b0;
            v2_reg   <= 1'b0;
        end else if (bus.clear_en) begin
            v1_reg   <= 1'b0;
            v2_reg   <= 1'b0;
        end else begin
            v1_reg <= bus.accum_en;
            v2_reg <= v1_reg;
            if (bus.accum_en) prod_reg <= OP_PROD_W'(b_reg) * OP_PROD_W'(c_reg);
        end
    end

    mac_sat_adder #(
        .ACC_W (ACC_W),
        .ADD_W (OP_PROD_W),
        .MODE  (MODE)
    ) u_adder (
        .acc_in    (acc_reg),
        .addend    (prod_reg),
        .sum_out   (sum_next),
        .carry_out (carry_next)
    );

    // Stage 2: fold the product into the accumulator, track sticky overflow and retire count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_reg <= '0;
            ovf_reg <= 1'b0;
            cnt_reg <= '0;
        end else if (bus.clear_en) begin
            acc_reg <= '0;
            ovf_reg <= 1'b0;
            cnt_reg <= '0;
        end else if (v1_reg) begin
            acc_reg <= sum_next;
            ovf_reg <= ovf_reg | carry_next;
            if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign bus.result_out = acc_reg;
    assign bus.overflow   = ovf_reg;
    assign bus.acc_count  = cnt_reg;
    assign bus.busy       = v1_reg | v2_reg;

endmodule

// File: tb/tb_mac_accum_unit.sv
// Bench for mac_accum_unit: wrap and clamp instances share stimulus, checked against a queue model.
module tb_mac_accum_unit;
    import mac_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] d_in  = '0;
    logic       lb_en = 1'b0;
    logic       lc_en = 1'b0;
    logic       ac_en = 1'b0;
    logic       cl_en = 1'b0;

    mac_accum_unit_if #(.DATA_W(8), .ACC_W(16), .CNT_W(4)) bus_w ();
    mac_accum_unit_if #(.DATA_W(8), .ACC_W(16), .CNT_W(4)) bus_s ();

    assign bus_w.data_in   = d_in;
    assign bus_w.load_b_en = lb_en;
    assign bus_w.load_c_en = lc_en;
    assign bus_w.accum_en  = ac_en;
    assign bus_w.clear_en  = cl_en;
    assign bus_s.data_in   = d_in;
    assign bus_s.load_b_en = lb_en;
    assign bus_s.load_c_en = lc_en;
    assign bus_s.accum_en  = ac_en;
    assign bus_s.clear_en  = cl_en;

    mac_accum_unit #(.DATA_W(8), .ACC_W(16), .CNT_W(4), .SATURATE(0)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bus_w.slave)
    );

    mac_accum_unit #(.DATA_W(8), .ACC_W(16), .CNT_W(4), .SATURATE(1)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s.slave)
    );

    int err_cnt   = 0;
    int check_cnt = 0;

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each accepted accumulate is a queued product due one edge later.
    typedef struct {
        int unsigned prod;
        int          due;
    } pend_t;

    pend_t       pend_q[$];
    int unsigned m_b = 0;
    int unsigned m_c = 0;
    int unsigned m_acc[2] = '{0, 0};
    bit          m_ovf = 1'b0;
    int unsigned m_cnt = 0;
    bit          m_busy = 1'b0;
    int          edge_n = 0;
    int          txn = 0;

    task automatic model_edge(input logic [7:0] d, input bit lb, input bit lc,
                              input bit ac, input bit cl, input bit rs);
        bit retired = 1'b0;
        edge_n++;
        if (!rs) begin
            m_b = 0; m_c = 0; m_acc = '{0, 0}; m_ovf = 0; m_cnt = 0;
            pend_q.delete();
        end else if (cl) begin
            m_acc = '{0, 0}; m_ovf = 0; m_cnt = 0;
            pend_q.delete();
        end else begin
            while (pend_q.size() > 0 && pend_q[0].due == edge_n) begin
                pend_t it = pend_q.pop_front();
                for (int k = 0; k < 2; k++) begin
                    int unsigned s = m_acc[k] + it.prod;
                    if (s > 65535) begin
                        m_ovf = 1'b1;
                        m_acc[k] = (k == 0) ? (s - 65536) : 65535;
                    end else begin
                        m_acc[k] = s;
                    end
                end
                if (m_cnt < 15) m_cnt++;
                retired = 1'b1;
            end
            if (ac) pend_q.push_back('{m_b * m_c, edge_n + 1});
            if (lb) m_b = d;
            if (lc) m_c = d;
        end
        m_busy = (pend_q.size() > 0) || retired;
    endtask

    // One clock of stimulus, then compare both instances against the model.
    task automatic step(input logic [7:0] d, input bit lb, input bit lc,
                        input bit ac, input bit cl, input bit rs);
        @(negedge clk);
        d_in = d; lb_en = lb; lc_en = lc; ac_en = ac; cl_en = cl; rst = rs;
        @(posedge clk);
        model_edge(d, lb, lc, ac, cl, rs);
        #1;
        txn++;
        $display("txn %0d: d=%02h lb=%0b lc=%0b ac=%0b cl=%0b rst=%0b -> res_w=%04h res_s=%04h ovf=%0b busy=%0b cnt=%0d",
                 txn, d, lb, lc, ac, cl, rs, bus_w.result_out, bus_s.result_out,
                 bus_w.overflow, bus_w.busy, bus_w.acc_count);
        check_val("result_wrap", bus_w.result_out, m_acc[0]);
        check_val("result_sat",  bus_s.result_out, m_acc[1]);
        check_val("ovf_wrap",    bus_w.overflow,   m_ovf);
        check_val("ovf_sat",     bus_s.overflow,   m_ovf);
        check_val("busy_wrap",   bus_w.busy,       m_busy);
        check_val("busy_sat",    bus_s.busy,       m_busy);
        check_val("count_wrap",  bus_w.acc_count,  m_cnt);
        check_val("count_sat",   bus_s.acc_count,  m_cnt);
    endtask

    task automatic idle();
        step(8'h00, 0, 0, 0, 0, 1);
    endtask

    task automatic load_bc(input logic [7:0] b, input logic [7:0] c);
        step(b, 1, 0, 0, 0, 1);
        step(c, 0, 1, 0, 0, 1);
    endtask

    task automatic clear();
        step(8'h00, 0, 0, 0, 1, 1);
    endtask

    initial begin
        // Reset state
        step(8'h00, 0, 0, 0, 0, 0);
        step(8'h00, 0, 0, 0, 0, 0);
        check_val("reset_result", bus_w.result_out, 16'h0000);
        check_val("reset_busy",   bus_w.busy,       1'b0);

        // Single accumulate 3*4
        load_bc(8'd3, 8'd4);
        step(8'h00, 0, 0, 1, 0, 1);
        check_val("single_busy1", bus_w.busy, 1'b1);
        idle();
        check_val("single_result", bus_w.result_out, 16'h000C);
        check_val("single_busy2",  bus_w.busy,       1'b1);
        idle();
        check_val("single_busy3",  bus_w.busy,       1'b0);
        check_val("single_count",  bus_w.acc_count,  4'd1);

        // Dot product [1,2,3,4].[5,6,7,8]
        clear();
        for (int i = 0; i < 4; i++) begin
            load_bc(8'(i + 1), 8'(i + 5));
            step(8'h00, 0, 0, 1, 0, 1);
        end
        idle();
        idle();
        check_val("dot_result", bus_w.result_out, 16'h0046);
        check_val("dot_count",  bus_w.acc_count,  4'd4);
        check_val("dot_ovf",    bus_w.overflow,   1'b0);

        // Overflow: 255*255 twice, then 1*1
        clear();
        step(8'hFF, 1, 1, 0, 0, 1);
        step(8'h00, 0, 0, 1, 0, 1);
        step(8'h00, 0, 0, 1, 0, 1);
        check_val("ovf_first_wrap", bus_w.result_out, 16'hFE01);
        idle();
        check_val("ovf_second_wrap", bus_w.result_out, 16'hFC02);
        check_val("ovf_second_sat",  bus_s.result_out, 16'hFFFF);
        check_val("ovf_flag_wrap",   bus_w.overflow,   1'b1);
        step(8'h01, 1, 1, 0, 0, 1);
        step(8'h00, 0, 0, 1, 0, 1);
        idle();
        check_val("ovf_sticky_wrap", bus_w.overflow,   1'b1);
        check_val("ovf_held_sat",    bus_s.result_out, 16'hFFFF);
        clear();
        check_val("ovf_cleared",     bus_s.overflow,   1'b0);

        // Same-cycle load with accumulate uses the old operand
        load_bc(8'd2, 8'd5);
        step(8'd9, 1, 0, 1, 0, 1);
        idle();
        idle();
        check_val("hazard_result", bus_w.result_out, 16'd10);

        // Clear beats accumulate
        step(8'h00, 0, 0, 1, 1, 1);
        check_val("clr_acc_result", bus_w.result_out, 16'd0);
        check_val("clr_acc_busy",   bus_w.busy,       1'b0);
        idle();
        check_val("clr_acc_count",  bus_w.acc_count,  4'd0);
        check_val("clr_acc_drop",   bus_w.result_out, 16'd0);

        // Reset mid-pipeline, then operands read as zero
        load_bc(8'd3, 8'd4);
        step(8'h00, 0, 0, 1, 0, 1);
        step(8'h00, 0, 0, 0, 0, 0);
        check_val("rstmid_busy",   bus_w.busy,       1'b0);
        check_val("rstmid_count",  bus_w.acc_count,  4'd0);
        idle();
        check_val("rstmid_result", bus_w.result_out, 16'd0);
        step(8'h00, 0, 0, 1, 0, 1);
        idle();
        idle();
        check_val("rstmid_zero_ops", bus_w.result_out, 16'd0);

        // Count saturation with back-to-back accumulates
        clear();
        step(8'h01, 1, 1, 0, 0, 1);
        for (int i = 0; i < 20; i++) step(8'h00, 0, 0, 1, 0, 1);
        idle();
        idle();
        check_val("cnt_sat_count",  bus_w.acc_count,  4'd15);
        check_val("cnt_sat_result", bus_w.result_out, 16'd20);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            bit         rs = ($urandom_range(0, 63) != 0);
            bit         cl = ($urandom_range(0, 15) == 0);
            bit         ac = 1'($urandom_range(0, 1));
            bit         lb = ($urandom_range(0, 3) == 0) && !cl;
            bit         lc = ($urandom_range(0, 3) == 0) && !cl;
            logic [7:0] d  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            step(d, lb, lc, ac, cl, rs);
        end
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
        $finish;
    end

endmodule
